// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 32;
  localparam int unsigned DEFAULT_ITERATIONS = DEFAULT_WIDTH / 2;

  // Controller states: operand capture, digit iteration, result write-back.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiple of the multiplicand selected by one Booth digit.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_sel_e;

  // Iteration counter width; at least one bit even for a single digit.
  function automatic int unsigned cnt_width(input int unsigned iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_ITERATIONS);

endpackage

// File: rtl/mult_seq_module_booth_recoder.sv
// Radix-4 Booth recoder: multiplier triplet {b[i+1], b[i], b[i-1]} to a digit select.
module booth_recoder
  import mult_pkg::*;
(
  input  logic [2:0] triplet,
  output booth_sel_e sel
);

  // Standard radix-4 digit table: value = -2*b[i+1] + b[i] + b[i-1].
  always_comb begin
    sel = ZERO;
    case (triplet)
      3'b000:  sel = ZERO;
      3'b001:  sel = POS1;
      3'b010:  sel = POS1;
      3'b011:  sel = POS2;
      3'b100:  sel = NEG2;
      3'b101:  sel = NEG1;
      3'b110:  sel = NEG1;
      3'b111:  sel = ZERO;
      default: sel = ZERO;
    endcase
  end

endmodule

// File: rtl/mult_seq_module.sv
// Iterative signed multiplier, one radix-4 Booth digit per cycle, with overflow flag.
module mult_seq_module
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned ITERATIONS = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_inputRDY,
  output logic             data_resultRDY
);

  localparam int unsigned CNT_W = cnt_width(ITERATIONS);
  // Two guard bits so that -2 * most-negative multiplicand is representable.
  localparam int unsigned ACC_W = WIDTH + 2;

  state_e             state_q, state_d;
  logic               load_c, step_c, finish_c;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               b_prev_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   count_q;

  booth_sel_e         sel_c;
  logic [ACC_W-1:0]   a_ext_c;
  logic [ACC_W-1:0]   a_dbl_c;
  logic [ACC_W-1:0]   term_c;
  logic [ACC_W-1:0]   sum_c;
  logic [2*WIDTH-1:0] product_c;
  logic               overflow_c;

  booth_recoder u_booth_recoder (
    .triplet ({b_q[1:0], b_prev_q}),
    .sel     (sel_c)
  );

  // Partial-product term selected by the current Booth digit.
  always_comb begin
    a_ext_c = {{2{a_q[WIDTH-1]}}, a_q};
    a_dbl_c = {a_ext_c[ACC_W-2:0], 1'b0};
    term_c  = '0;
    case (sel_c)
      POS1:    term_c = a_ext_c;
      POS2:    term_c = a_dbl_c;
      NEG1:    term_c = ACC_W'(~a_ext_c + ACC_W'(1));
      NEG2:    term_c = ACC_W'(~a_dbl_c + ACC_W'(1));
      default: term_c = '0;
    endcase
    sum_c = ACC_W'(acc_q + term_c);
  end

  // Full product after the last shift; overflow when the upper half plus the
  // result sign bit are not a pure sign extension.
  always_comb begin
    product_c  = {acc_q[WIDTH-1:0], b_q};
    overflow_c = !((&product_c[2*WIDTH-1:WIDTH-1]) || !(|product_c[2*WIDTH-1:WIDTH-1]));
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d  = state_q;
    load_c   = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_MULT) begin
          load_c  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step_c = 1'b1;
        if (count_q == CNT_W'(ITERATIONS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        finish_c = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, then accumulate and arithmetic-shift {acc, b} right by two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      b_prev_q <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (load_c) begin
      a_q      <= data_operandA;
      b_q      <= data_operandB;
      b_prev_q <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (step_c) begin
      acc_q    <= {{2{sum_c[ACC_W-1]}}, sum_c[ACC_W-1:2]};
      b_q      <= {sum_c[1:0], b_q[WIDTH-1:2]};
      b_prev_q <= b_q[1];
      count_q  <= CNT_W'(count_q + CNT_W'(1));
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      data_inputRDY  <= 1'b1;
      data_resultRDY <= 1'b0;
    end else begin
      data_inputRDY  <= (state_d == IDLE);
      data_resultRDY <= finish_c;
      if (finish_c) begin
        data_result    <= product_c[WIDTH-1:0];
        data_exception <= overflow_c;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_module.sv
// Scoreboard bench for mult_seq_module: driver pushes expected results, monitor pops on resultRDY.
module tb_mult_seq_module;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         exc;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic         ctrl_MULT = 1'b0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_inputRDY;
  logic         data_resultRDY;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  logic [W-1:0] held_res = '0;
  logic         held_exc = 1'b0;

  mult_seq_module #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_inputRDY  (data_inputRDY),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact 64-bit signed product, truncated, with fit test.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb_l, p, lo_ext;
    exp_t   e;
    sa     = $signed(a);
    sb_l   = $signed(b);
    p      = sa * sb_l;
    e.res  = p[W-1:0];
    lo_ext = $signed(e.res);
    e.exc  = (p != lo_ext);
    sb.push_back(e);
  endtask

  // Monitor: compare on each result pulse, otherwise require outputs to hold.
  always @(negedge clock) begin
    if (!reset_n) begin
      held_res = '0;
      held_exc = 1'b0;
    end else if (data_resultRDY) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", 64'(data_result), 64'(mon_e.res));
        check("exception", 64'(data_exception), 64'(mon_e.exc));
        held_res = mon_e.res;
        held_exc = mon_e.exc;
      end
    end else begin
      check("hold", 64'({data_result, data_exception}), 64'({held_res, held_exc}));
    end
  end

  // Wait for inputRDY, present operands for one edge, record acceptance cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = 0;
    while (!data_inputRDY && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!data_inputRDY) check("ready_timeout", 64'd0, 64'd1);
    data_operandA = a;
    data_operandB = b;
    push_exp(a, b);
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    acc_cyc   = cyc;
    ctrl_MULT = 1'b0;
  endtask

  // Wait for the result pulse (bounded); check latency and busy-phase inputRDY.
  task automatic wait_done(input bit chk_low);
    int low;
    low = 0;
    do begin
      @(negedge clock);
      if (!data_inputRDY) low++;
    end while (!data_resultRDY && (cyc - acc_cyc) < 40);
    check("latency", 64'(cyc - acc_cyc), 64'd17);
    if (chk_low) check("busy_inputRDY_low", 64'(low), 64'd17);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return W'($urandom_range(0, 255));
      4:       return W'(-$signed(W'($urandom_range(0, 65535))));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int pc[3];
    int t;

    // Reset state.
    #12;
    check("rst_result", 64'(data_result), 64'd0);
    check("rst_exception", 64'(data_exception), 64'd0);
    check("rst_inputRDY", 64'(data_inputRDY), 64'd1);
    check("rst_resultRDY", 64'(data_resultRDY), 64'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);

    // Directed products including the sign and overflow corners.
    issue(32'd3, 32'd7);                  wait_done(1'b1);
    issue(32'hFFFF_FFFB, 32'd6);          wait_done(1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_done(1'b1);
    issue(32'h0001_0000, 32'h0001_0000);  wait_done(1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF);  wait_done(1'b1);
    issue(32'h8000_0000, 32'h8000_0000);  wait_done(1'b1);
    issue(32'h8000_0000, 32'd2);          wait_done(1'b1);
    issue(32'd0, 32'h8000_0000);          wait_done(1'b1);

    // A request while busy is ignored and the new operands are not sampled.
    issue(32'd12, 32'd12);
    repeat (4) @(posedge clock);
    #1;
    data_operandA = 32'd99;
    data_operandB = 32'd99;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1 ctrl_MULT = 1'b0;
    wait_done(1'b0);

    // Reset in the middle of an operation discards it.
    issue(32'd7, 32'd9);
    repeat (8) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_result", 64'(data_result), 64'd0);
    check("midrst_exception", 64'(data_exception), 64'd0);
    check("midrst_inputRDY", 64'(data_inputRDY), 64'd1);
    check("midrst_resultRDY", 64'(data_resultRDY), 64'd0);
    sb.delete();
    @(negedge clock);
    #2 reset_n = 1'b1;
    issue(32'd7, 32'd9);
    wait_done(1'b1);

    // ctrl_MULT held high: back-to-back acceptances every 18 cycles.
    @(negedge clock);
    repeat (3) push_exp(32'd2, 32'd3);
    data_operandA = 32'd2;
    data_operandB = 32'd3;
    ctrl_MULT     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (!data_resultRDY && t < 40);
      pc[i] = cyc;
    end
    ctrl_MULT = 1'b0;
    check("b2b_gap1", 64'(pc[1] - pc[0]), 64'd18);
    check("b2b_gap2", 64'(pc[2] - pc[1]), 64'd18);
    repeat (25) @(negedge clock);

    // Randomized operands against the reference product.
    for (int i = 0; i < 30; i++) begin
      issue(pick(), pick());
      wait_done(1'b1);
    end

    repeat (5) @(negedge clock);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
